// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for a single-ported
// main memory. Port 0 is the instruction-cache refill path, port 1 the
// data-cache refill/writeback path. Each grant produces exactly one
// single-cycle memory command, waits MEM_LATENCY cycles for the registered
// read data, then pulses the granted port's ack for one cycle.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   req0/we0/addr0/wdata0         port 0 request, write enable, word address, write data
//   ack0/rdata0                   port 0 completion pulse and read data
//   req1/we1/addr1/wdata1         port 1 request side
//   ack1/rdata1                   port 1 completion side
//   mem_enable/mem_read/mem_write memory command strobes (ISSUE cycle only)
//   mem_address/mem_write_data    latched command address and write data
//   mem_read_data                 registered read data from memory
//   busy                          high whenever the sequencer is not idle

module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  logic [1:0]            state_r;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic                  grant_r;
  // 1 means port 1 was granted most recently, so port 0 wins the next tie.
  logic                  last_grant_r;

  logic                  grant_valid_s;
  logic                  grant_port_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // Arbitration: single requester wins outright, a tie goes to the port not granted last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    case ({req1, req0})
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_port_s  = ~last_grant_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
      end
    endcase
  end

  // Mux the winning port's transaction fields for latching at grant time.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (grant_port_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Sequencer FSM; every output is driven straight from a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      we_r           <= 1'b0;
      grant_r        <= 1'b0;
      last_grant_r   <= 1'b1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_enable     <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (grant_valid_s) begin
            // The command strobes are registered here so they appear in ISSUE.
            we_r           <= sel_we_s;
            grant_r        <= grant_port_s;
            mem_enable     <= 1'b1;
            mem_read       <= ~sel_we_s;
            mem_write      <= sel_we_s;
            mem_address    <= sel_addr_s;
            mem_write_data <= sel_wdata_s;
            busy           <= 1'b1;
            state_r        <= ST_ISSUE;
          end else begin
            busy           <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_enable <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          cnt_r      <= LAT_LOAD;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          // Count of 1 marks the cycle in which mem_read_data is valid.
          if (cnt_r == 4'd1) begin
            if (!we_r) begin
              if (grant_r) begin
                rdata1 <= mem_read_data;
              end else begin
                rdata0 <= mem_read_data;
              end
            end
            ack0    <= ~grant_r;
            ack1    <= grant_r;
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack0         <= 1'b0;
          ack1         <= 1'b0;
          last_grant_r <= grant_r;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          mem_enable <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  mem_arbiter_checker #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_checker (
    .clock      (clock),
    .reset      (reset),
    .mem_enable (mem_enable),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ack0       (ack0),
    .ack1       (ack1),
    .busy       (busy)
  );

endmodule

// mem_arbiter_checker: simulation-only invariants for mem_arbiter.
// Ports: clock/reset plus the observed command strobes, acks and busy.
module mem_arbiter_checker #(
  parameter int MEM_LATENCY = 1
) (
  input logic clock,
  input logic reset,
  input logic mem_enable,
  input logic mem_read,
  input logic mem_write,
  input logic ack0,
  input logic ack1,
  input logic busy
);

  // Parameter range and command/ack invariants, checked every cycle out of reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (MEM_LATENCY >= 1 && MEM_LATENCY <= 15);
      assert (!mem_enable || (mem_read ^ mem_write));
      assert (!(ack0 && ack1));
      assert (!mem_enable || busy);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench. Instance 0 uses MEM_LATENCY=1,
// instance 1 uses MEM_LATENCY=4; each has its own memory model whose read data
// is only valid in the single cycle the latency dictates (junk otherwise).

module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [1:0] req0 = 2'b00, we0 = 2'b00, req1 = 2'b00, we1 = 2'b00;
  logic [9:0]  addr0  [2];
  logic [9:0]  addr1  [2];
  logic [31:0] wdata0 [2];
  logic [31:0] wdata1 [2];
  logic [1:0]  ack0, ack1, mem_enable, mem_read, mem_write, busy;
  logic [31:0] rdata0 [2];
  logic [31:0] rdata1 [2];
  logic [9:0]  mem_address [2];
  logic [31:0] mem_write_data [2];
  logic [31:0] mem_read_data [2];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [31:0] mem [0:1023];
    logic [32:0] pipe [0:3];

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .ack0(ack0[g]), .rdata0(rdata0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .ack1(ack1[g]), .rdata1(rdata1[g]),
      .mem_enable(mem_enable[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_address(mem_address[g]), .mem_write_data(mem_write_data[g]),
      .mem_read_data(mem_read_data[g]), .busy(busy[g])
    );

    // Memory model: preload during reset, write on command, read through a valid pipe.
    always @(posedge clock) begin
      if (reset) begin
        mem[10'h010] <= 32'h01010101;
        mem[10'h020] <= 32'h02020202;
        mem[10'h3FE] <= 32'h55AA55AA;
        mem[10'h3FF] <= 32'h12345678;
      end else if (mem_enable[g] && mem_write[g]) begin
        mem[mem_address[g]] <= mem_write_data[g];
      end
      pipe[0] <= {mem_enable[g] && mem_read[g] && !reset, mem[mem_address[g]]};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_read_data[g] = pipe[LAT-1][32] ? pipe[LAT-1][31:0] : 32'hBAD0BAD0;
  end

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One transaction on one port; reports what was observed cycle by cycle.
  task automatic do_txn(input int inst, input int port, input logic we,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output int cmd_cyc, output logic [9:0] cmd_addr,
                        output logic cmd_wr, output logic cmd_rd,
                        output int ack_cyc, output logic other_ack, output logic busy_c1);
    @(negedge clock);
    if (port == 0) begin
      we0[inst] = we; addr0[inst] = addr; wdata0[inst] = wdata; req0[inst] = 1'b1;
    end else begin
      we1[inst] = we; addr1[inst] = addr; wdata1[inst] = wdata; req1[inst] = 1'b1;
    end
    cmd_cyc = -1; ack_cyc = -1; other_ack = 1'b0; busy_c1 = 1'b0;
    cmd_addr = 10'h000; cmd_wr = 1'b0; cmd_rd = 1'b0;
    for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
      @(negedge clock);
      if (c == 1) busy_c1 = busy[inst];
      if (mem_enable[inst] && cmd_cyc < 0) begin
        cmd_cyc = c; cmd_addr = mem_address[inst];
        cmd_wr = mem_write[inst]; cmd_rd = mem_read[inst];
      end
      if ((port == 0) ? ack1[inst] : ack0[inst]) other_ack = 1'b1;
      if ((port == 0) ? ack0[inst] : ack1[inst]) ack_cyc = c;
    end
    req0[inst] = 1'b0;
    req1[inst] = 1'b0;
  endtask

  // Both ports request continuously (writes) until n acks; grants must alternate from port 0.
  task automatic run_contention(input int inst, input int n);
    int acks = 0;
    int both = 0;
    int c = 0;
    int seen;
    @(negedge clock);
    we0[inst] = 1'b1; addr0[inst] = 10'h100; wdata0[inst] = 32'h00000100;
    we1[inst] = 1'b1; addr1[inst] = 10'h101; wdata1[inst] = 32'h00000101;
    req0[inst] = 1'b1; req1[inst] = 1'b1;
    while (acks < n && c < 80) begin
      @(negedge clock);
      c++;
      if (ack0[inst] && ack1[inst]) begin
        both++;
      end else if (ack0[inst] || ack1[inst]) begin
        seen = ack0[inst] ? 0 : 1;
        check($sformatf("i%0d_grant_order_%0d", inst, acks), 64'(seen), 64'(acks % 2));
        acks++;
      end
    end
    req0[inst] = 1'b0; req1[inst] = 1'b0;
    check($sformatf("i%0d_contention_acks", inst), 64'(acks), 64'(n));
    check($sformatf("i%0d_contention_dual_ack", inst), 64'(both), 64'd0);
  endtask

  initial begin
    int cmd_cyc, ack_cyc, cnt;
    logic [9:0] cmd_addr;
    logic cmd_wr, cmd_rd, other_ack, busy_c1;

    for (int i = 0; i < 2; i++) begin
      addr0[i] = 10'h000; addr1[i] = 10'h000; wdata0[i] = 32'h0; wdata1[i] = 32'h0;
    end

    vecs[0] = '{0, 0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    vecs[1] = '{0, 0, 1'b0, 10'h005, 32'h00000000, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{0, 1, 1'b1, 10'h0AA, 32'h0BADF00D, 32'hDEADBEEF, 32'h00000000};
    vecs[3] = '{0, 1, 1'b0, 10'h0AA, 32'h00000000, 32'hDEADBEEF, 32'h0BADF00D};
    vecs[4] = '{0, 0, 1'b1, 10'h005, 32'h11111111, 32'hDEADBEEF, 32'h0BADF00D};
    vecs[5] = '{0, 1, 1'b0, 10'h005, 32'h00000000, 32'hDEADBEEF, 32'h11111111};
    vecs[6] = '{0, 0, 1'b0, 10'h100, 32'h00000000, 32'h00000100, 32'h11111111};
    vecs[7] = '{1, 1, 1'b0, 10'h3FF, 32'h00000000, 32'h00000000, 32'h12345678};
    vecs[8] = '{1, 0, 1'b0, 10'h3FE, 32'h00000000, 32'h55AA55AA, 32'h12345678};

    // Reset for two cycles, then every output must be zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d_reset_strobes", i),
            {58'd0, ack0[i], ack1[i], mem_enable[i], mem_read[i], mem_write[i], busy[i]}, 64'd0);
      check($sformatf("i%0d_reset_addr", i), 64'(mem_address[i]), 64'd0);
      check($sformatf("i%0d_reset_wdata", i), 64'(mem_write_data[i]), 64'd0);
      check($sformatf("i%0d_reset_rdata", i), {rdata0[i], rdata1[i]}, 64'd0);
    end
    reset = 1'b0;

    // Idle with no requests: no command, never busy.
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (mem_enable != 2'b00 || busy != 2'b00) cnt++;
    end
    check("idle_no_activity", 64'(cnt), 64'd0);

    // First contention after reset: 0,1,0,1.
    run_contention(0, 4);

    // Table of single transactions.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].inst, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             cmd_cyc, cmd_addr, cmd_wr, cmd_rd, ack_cyc, other_ack, busy_c1);
      check($sformatf("v%0d_cmd_cycle", i), 64'(cmd_cyc), 64'd1);
      check($sformatf("v%0d_cmd_addr", i), 64'(cmd_addr), 64'(vecs[i].addr));
      check($sformatf("v%0d_cmd_wr_rd", i), {62'd0, cmd_wr, cmd_rd}, {62'd0, vecs[i].we, ~vecs[i].we});
      check($sformatf("v%0d_busy", i), 64'(busy_c1), 64'd1);
      check($sformatf("v%0d_ack_cycle", i), 64'(ack_cyc), 64'((vecs[i].inst == 0) ? 3 : 6));
      check($sformatf("v%0d_other_ack", i), 64'(other_ack), 64'd0);
      check($sformatf("v%0d_rdata0", i), 64'(rdata0[vecs[i].inst]), 64'(vecs[i].exp_r0));
      check($sformatf("v%0d_rdata1", i), 64'(rdata1[vecs[i].inst]), 64'(vecs[i].exp_r1));
    end

    // Address latching: addr1 changes in ISSUE; the command keeps the granted address.
    @(negedge clock);
    we1[0] = 1'b0; addr1[0] = 10'h010; req1[0] = 1'b1;
    @(negedge clock);
    check("latch_issue_addr", {53'd0, mem_enable[0], mem_address[0]}, {53'd0, 1'b1, 10'h010});
    addr1[0] = 10'h020;
    @(negedge clock);
    check("latch_wait_addr", 64'(mem_address[0]), 64'h010);
    @(negedge clock);
    check("latch_ack1", 64'(ack1[0]), 64'd1);
    check("latch_rdata1", 64'(rdata1[0]), 64'h01010101);
    req1[0] = 1'b0;

    // Reset during the WAIT of a port 0 read on the latency-4 instance.
    @(negedge clock);
    we0[1] = 1'b0; addr0[1] = 10'h3FE; req0[1] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_wait_busy_before", 64'(busy[1]), 64'd1);
    @(negedge clock);
    reset = 1'b1; req0[1] = 1'b0;
    @(negedge clock);
    check("rst_wait_state", {61'd0, busy[1], ack0[1], mem_enable[1]}, 64'd0);
    check("rst_wait_rdata0", 64'(rdata0[1]), 64'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (ack0[1] || ack1[1]) cnt++;
    end
    check("rst_wait_no_ack", 64'(cnt), 64'd0);
    run_contention(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
